// File: rtl/ram_reader_pkg.sv
// Shared types and constants for the RAM stream reader.
// Optional feature macro: RAM_READER_LOOP_EN.
package ram_reader_pkg;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN,
        DONE
    } state_t;

    localparam int MIN_FIFO_DEPTH = 3;

    // Width of an occupancy counter able to hold 0..depth.
    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/ram_stream_reader_if.sv
// Valid/ready output stream of the RAM stream reader, with a last-word marker.
interface ram_stream_reader_if #(
    parameter int DSIZE = 8
);
    logic [DSIZE-1:0] m_data;
    logic             m_valid;
    logic             m_ready;
    logic             m_last;

    modport master (output m_data, output m_valid, output m_last, input m_ready);
    modport slave  (input m_data, input m_valid, input m_last, output m_ready);

endinterface

// File: rtl/ram_reader_fifo.sv
// Synchronous first-word fall-through FIFO with occupancy output.
// The head entry drives rd_data directly from a register.
module ram_reader_fifo
    import ram_reader_pkg::*;
#(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4,
    localparam int CW   = count_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty,
    output logic [CW-1:0]    count
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_read;

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign do_read = rd_en && !empty;
    assign empty   = (count == '0);
    assign rd_data = mem[rd_ptr];

    // Storage is cleared on reset so the head reads as zero while idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= bump(wr_ptr);
            end
            if (do_read) begin
                rd_ptr <= bump(rd_ptr);
            end
            case ({wr_en, do_read})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ram_stream_reader.sv
// Sweeps a block of RAM addresses and streams the words out with backpressure.
// Define RAM_READER_LOOP_EN to repeat the pass from base until stop is requested.
module ram_stream_reader
    import ram_reader_pkg::*;
#(
    parameter int DSIZE      = 8,
    parameter int ASIZE      = 10,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [ASIZE-1:0]    base,
    input  logic [ASIZE:0]      len,
    input  logic                stop,
    output logic                busy,
    output logic                done,
    output logic [ASIZE-1:0]    ram_addr,
    output logic                ram_en,
    input  logic [DSIZE-1:0]    ram_dout,
    ram_stream_reader_if.master strm
);

    localparam int CW = count_width(FIFO_DEPTH);

    if (FIFO_DEPTH < MIN_FIFO_DEPTH) begin : g_depth_check
        $error("ram_stream_reader: FIFO_DEPTH must be at least %0d", MIN_FIFO_DEPTH);
    end

    state_t         state;
    logic [ASIZE:0] remaining;
    logic           inflight_q;
    logic           final_q;
    logic [CW-1:0]  count;
    logic [CW:0]    occupancy;
    logic           fifo_empty;
    logic [DSIZE:0] head;
    logic           pop;
    logic           final_issue;
    logic           drain_done;

`ifdef RAM_READER_LOOP_EN
    logic [ASIZE-1:0] base_q;
    logic [ASIZE:0]   len_q;
    logic             stop_q;
`else
    wire unused_stop = stop;
`endif

    // Reads are throttled only by registered occupancy, never by m_ready.
    assign occupancy   = {1'b0, count} + {{CW{1'b0}}, inflight_q};
    assign ram_en      = (state == READ) && (occupancy < (CW+1)'(FIFO_DEPTH));
    assign final_issue = ram_en && (remaining == (ASIZE+1)'(1));

    assign pop        = !fifo_empty && strm.m_ready;
    assign drain_done = !inflight_q && ((count == '0) || ((count == CW'(1)) && pop));

    assign strm.m_valid = !fifo_empty;
    assign strm.m_data  = head[DSIZE-1:0];
    assign strm.m_last  = !fifo_empty && head[DSIZE];

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            ram_addr   <= '0;
            remaining  <= '0;
            inflight_q <= 1'b0;
            final_q    <= 1'b0;
`ifdef RAM_READER_LOOP_EN
            base_q     <= '0;
            len_q      <= '0;
            stop_q     <= 1'b0;
`endif
        end else begin
            inflight_q <= ram_en;
            final_q    <= final_issue;
            done       <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        busy      <= 1'b1;
                        ram_addr  <= base;
                        remaining <= len;
`ifdef RAM_READER_LOOP_EN
                        base_q    <= base;
                        len_q     <= len;
                        stop_q    <= 1'b0;
`endif
                        if (len == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= READ;
                        end
                    end
                end
                READ: begin
`ifdef RAM_READER_LOOP_EN
                    if (stop) begin
                        stop_q <= 1'b1;
                    end
`endif
                    if (ram_en) begin
                        ram_addr  <= ram_addr + ASIZE'(1);
                        remaining <= remaining - (ASIZE+1)'(1);
                        if (final_issue) begin
`ifdef RAM_READER_LOOP_EN
                            // A stop seen this pass, or right now, ends at this pass.
                            if (stop_q || stop) begin
                                state <= DRAIN;
                            end else begin
                                ram_addr  <= base_q;
                                remaining <= len_q;
                            end
`else
                            state <= DRAIN;
`endif
                        end
                    end
                end
                DRAIN: begin
                    if (drain_done) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    ram_reader_fifo #(
        .WIDTH (DSIZE + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (inflight_q),
        .wr_data ({final_q, ram_dout}),
        .rd_en   (pop),
        .rd_data (head),
        .empty   (fifo_empty),
        .count   (count)
    );

endmodule

// File: tb/tb_ram_stream_reader.sv
// Self-checking bench for ram_stream_reader against a RAM model and a stream scoreboard.
module tb_ram_stream_reader;

    localparam int DSIZE  = 8;
    localparam int ASIZE  = 10;
    localparam int DEPTH  = 4;
    localparam int NWORDS = 1024;

    logic             clk   = 1'b0;
    logic             rst   = 1'b1;
    logic             start = 1'b0;
    logic             stop  = 1'b0;
    logic [ASIZE-1:0] base  = '0;
    logic [ASIZE:0]   len   = '0;
    logic             busy;
    logic             done;
    logic [ASIZE-1:0] ram_addr;
    logic             ram_en;
    logic [DSIZE-1:0] ram_dout;

    int checks = 0;
    int errors = 0;

    ram_stream_reader_if #(.DSIZE(DSIZE)) strm ();

    ram_stream_reader #(
        .DSIZE      (DSIZE),
        .ASIZE      (ASIZE),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .base     (base),
        .len      (len),
        .stop     (stop),
        .busy     (busy),
        .done     (done),
        .ram_addr (ram_addr),
        .ram_en   (ram_en),
        .ram_dout (ram_dout),
        .strm     (strm)
    );

    always #5 clk = ~clk;

    // Single-port RAM with a one-cycle registered, enable-gated read.
    logic [DSIZE-1:0] ram_mem [NWORDS];
    initial begin
        for (int i = 0; i < NWORDS; i++) ram_mem[i] = 8'(i) ^ 8'hA5;
    end
    always @(posedge clk) if (ram_en) ram_dout <= ram_mem[ram_addr];

    bit ready_rand = 1'b0;
    always @(posedge clk) begin
        #1;
        strm.m_ready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Monitor: records transfers and issued addresses, and tracks outstanding reads.
    int         clear_gen = 0;
    int         seen_gen = 0;
    int         cyc = 0;
    int         outstanding = 0;
    int         issue_viol = 0;
    int         hold_viol = 0;
    int         done_cnt = 0;
    int         en_cnt = 0;
    int         first_xfer_cyc = 0;
    int         last_xfer_cyc = 0;
    int         done_cyc = 0;
    logic [7:0] q_data [$];
    bit         q_last [$];
    int         addr_q [$];
    bit         stalled = 1'b0;
    logic [7:0] held_data;
    logic       held_last;

    always @(negedge clk) begin
        cyc++;
        if (clear_gen != seen_gen) begin
            seen_gen = clear_gen;
            q_data.delete();
            q_last.delete();
            addr_q.delete();
            issue_viol = 0;
            hold_viol  = 0;
            done_cnt   = 0;
            en_cnt     = 0;
        end
        if (rst) begin
            outstanding = 0;
            stalled     = 1'b0;
        end else begin
            if (stalled && (strm.m_valid !== 1'b1 || strm.m_data !== held_data ||
                            strm.m_last !== held_last)) hold_viol++;
            if (ram_en === 1'b1) begin
                if (outstanding >= DEPTH) issue_viol++;
                en_cnt++;
                outstanding++;
                addr_q.push_back(int'(ram_addr));
            end
            if (strm.m_valid === 1'b1 && strm.m_ready === 1'b1) begin
                q_data.push_back(strm.m_data);
                q_last.push_back(strm.m_last);
                if (q_data.size() == 1) first_xfer_cyc = cyc;
                last_xfer_cyc = cyc;
                outstanding--;
            end
            stalled   = (strm.m_valid === 1'b1) && (strm.m_ready !== 1'b1);
            held_data = strm.m_data;
            held_last = strm.m_last;
            if (done === 1'b1) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    function automatic logic [7:0] model_word(input int addr);
        return 8'(addr % NWORDS) ^ 8'hA5;
    endfunction

    // Counts received words that differ from `passes` sweeps of l words from b.
    function automatic int stream_mismatches(input int b, input int l, input int passes);
        int bad;
        int off;
        bad = 0;
        for (int k = 0; k < l * passes && k < q_data.size(); k++) begin
            off = k % l;
            if (q_data[k] !== model_word(b + off) || q_last[k] !== (off == l - 1)) bad++;
        end
        return bad;
    endfunction

    task automatic new_scenario();
        clear_gen++;
        @(negedge clk);
    endtask

    task automatic drive_start(input int b, input int l);
        @(posedge clk); #1;
        start = 1'b1;
        base  = ASIZE'(b);
        len   = (ASIZE+1)'(l);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            if (done === 1'b1) ok = 1'b1;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got %b want 0", done); end
        checks++; if (ram_en !== 1'b0) begin errors++; $display("[TB] FAIL reset_ram_en got %b want 0", ram_en); end
        checks++; if (ram_addr !== '0) begin errors++; $display("[TB] FAIL reset_ram_addr got %0d want 0", ram_addr); end
        checks++; if (strm.m_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_m_valid got %b want 0", strm.m_valid); end
        checks++; if (strm.m_last !== 1'b0) begin errors++; $display("[TB] FAIL reset_m_last got %b want 0", strm.m_last); end
        checks++; if (strm.m_data !== '0) begin errors++; $display("[TB] FAIL reset_m_data got %h want 00", strm.m_data); end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        bit ok;
        ready_rand = 1'b0;
        new_scenario();
        drive_start(5, 4);
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL basic_busy got %b want 1", busy); end
        checks++; if (ram_en !== 1'b1 || ram_addr !== 10'd5) begin errors++; $display("[TB] FAIL basic_first_read got en=%b addr=%0d want en=1 addr=5", ram_en, ram_addr); end
        @(posedge clk); #1;
        checks++; if (strm.m_valid !== 1'b0) begin errors++; $display("[TB] FAIL basic_early_valid got %b want 0", strm.m_valid); end
        @(posedge clk); #1;
        checks++; if (strm.m_valid !== 1'b1 || strm.m_data !== model_word(5)) begin errors++; $display("[TB] FAIL basic_first_word got valid=%b data=%h want valid=1 data=%h", strm.m_valid, strm.m_data, model_word(5)); end
        wait_done(30, ok);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL basic_done_timeout got none want done"); end
        checks++; if (q_data.size() != 4) begin errors++; $display("[TB] FAIL basic_count got %0d want 4", q_data.size()); end
        checks++; if (stream_mismatches(5, 4, 1) != 0) begin errors++; $display("[TB] FAIL basic_stream got %0d bad words want 0", stream_mismatches(5, 4, 1)); end
        checks++; if (last_xfer_cyc - first_xfer_cyc != 3) begin errors++; $display("[TB] FAIL basic_throughput got %0d cycles want 3", last_xfer_cyc - first_xfer_cyc); end
        checks++; if (done_cyc - last_xfer_cyc != 1) begin errors++; $display("[TB] FAIL basic_done_timing got %0d want 1", done_cyc - last_xfer_cyc); end
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("[TB] FAIL basic_idle got busy=%b done=%b want 0 0", busy, done); end
    endtask

    task automatic test_backpressure();
        bit ok;
        ready_rand = 1'b1;
        new_scenario();
        drive_start(0, 16);
        wait_done(300, ok);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL bp_done_timeout got none want done"); end
        checks++; if (q_data.size() != 16) begin errors++; $display("[TB] FAIL bp_count got %0d want 16", q_data.size()); end
        checks++; if (stream_mismatches(0, 16, 1) != 0) begin errors++; $display("[TB] FAIL bp_stream got %0d bad words want 0", stream_mismatches(0, 16, 1)); end
        checks++; if (issue_viol != 0) begin errors++; $display("[TB] FAIL bp_issue_rule got %0d violations want 0", issue_viol); end
        checks++; if (hold_viol != 0) begin errors++; $display("[TB] FAIL bp_hold got %0d violations want 0", hold_viol); end
        checks++; if (done_cnt != 1) begin errors++; $display("[TB] FAIL bp_done_pulses got %0d want 1", done_cnt); end
        ready_rand = 1'b0;
    endtask

    task automatic test_wrap_edges();
        bit ok;
        new_scenario();
        drive_start(1022, 3);
        wait_done(40, ok);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL wrap_done_timeout got none want done"); end
        checks++; if (addr_q.size() != 3 || addr_q[0] != 1022 || addr_q[1] != 1023 || addr_q[2] != 0) begin errors++; $display("[TB] FAIL wrap_addresses got n=%0d first=%0d want 1022,1023,0", addr_q.size(), (addr_q.size() > 0) ? addr_q[0] : -1); end
        checks++; if (stream_mismatches(1022, 3, 1) != 0 || q_data.size() != 3) begin errors++; $display("[TB] FAIL wrap_stream got n=%0d bad=%0d want 3 0", q_data.size(), stream_mismatches(1022, 3, 1)); end

        new_scenario();
        drive_start(7, 0);
        checks++; if (done !== 1'b1) begin errors++; $display("[TB] FAIL len0_done got %b want 1", done); end
        repeat (4) @(posedge clk);
        #1;
        checks++; if (en_cnt != 0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL len0_quiet got reads=%0d busy=%b want 0 0", en_cnt, busy); end

        new_scenario();
        drive_start(512, 1024);
        wait_done(1300, ok);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL full_done_timeout got none want done"); end
        checks++; if (q_data.size() != 1024) begin errors++; $display("[TB] FAIL full_count got %0d want 1024", q_data.size()); end
        checks++; if (stream_mismatches(512, 1024, 1) != 0) begin errors++; $display("[TB] FAIL full_stream got %0d bad words want 0", stream_mismatches(512, 1024, 1)); end
    endtask

    task automatic test_busy_start();
        bit ok;
        ready_rand = 1'b1;
        new_scenario();
        drive_start(10, 10);
        repeat (3) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL busy_flag got %b want 1", busy); end
        start = 1'b1;
        base  = 10'd100;
        len   = 11'd5;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(200, ok);
        repeat (10) @(posedge clk);
        #1;
        checks++; if (!ok) begin errors++; $display("[TB] FAIL busy_done_timeout got none want done"); end
        checks++; if (q_data.size() != 10 || stream_mismatches(10, 10, 1) != 0) begin errors++; $display("[TB] FAIL busy_stream got n=%0d bad=%0d want 10 0", q_data.size(), stream_mismatches(10, 10, 1)); end
        checks++; if (done_cnt != 1) begin errors++; $display("[TB] FAIL busy_done_pulses got %0d want 1", done_cnt); end
        ready_rand = 1'b0;
    endtask

    task automatic test_reset_mid();
        bit ok;
        bit reached;
        new_scenario();
        drive_start(200, 10);
        reached = 1'b0;
        for (int i = 0; i < 50 && !reached; i++) begin
            @(negedge clk);
            if (q_data.size() >= 3) reached = 1'b1;
        end
        checks++; if (!reached) begin errors++; $display("[TB] FAIL midrst_reach got %0d words want 3", q_data.size()); end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++; if ({busy, done, ram_en, strm.m_valid, strm.m_last, ram_addr, strm.m_data} !== '0) begin errors++; $display("[TB] FAIL midrst_outputs got busy=%b done=%b en=%b valid=%b last=%b addr=%0d data=%h want all 0", busy, done, ram_en, strm.m_valid, strm.m_last, ram_addr, strm.m_data); end
        repeat (6) @(posedge clk);
        #1;
        checks++; if (done_cnt != 0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL midrst_no_done got done=%0d busy=%b want 0 0", done_cnt, busy); end
        new_scenario();
        drive_start(300, 4);
        wait_done(40, ok);
        checks++; if (!ok || q_data.size() != 4 || stream_mismatches(300, 4, 1) != 0) begin errors++; $display("[TB] FAIL midrst_restart got ok=%b n=%0d bad=%0d want 1 4 0", ok, q_data.size(), stream_mismatches(300, 4, 1)); end
    endtask

`ifdef RAM_READER_LOOP_EN
    task automatic test_loop();
        bit ok;
        bit reached;
        new_scenario();
        drive_start(0, 3);
        reached = 1'b0;
        for (int i = 0; i < 30 && !reached; i++) begin
            @(negedge clk);
            if (en_cnt >= 4) reached = 1'b1;
        end
        @(posedge clk); #1;
        stop = 1'b1;
        @(posedge clk); #1;
        stop = 1'b0;
        wait_done(60, ok);
        checks++; if (!reached || !ok) begin errors++; $display("[TB] FAIL loop_progress got reached=%b done=%b want 1 1", reached, ok); end
        checks++; if (q_data.size() != 6) begin errors++; $display("[TB] FAIL loop_count got %0d want 6", q_data.size()); end
        checks++; if (stream_mismatches(0, 3, 2) != 0) begin errors++; $display("[TB] FAIL loop_stream got %0d bad words want 0", stream_mismatches(0, 3, 2)); end
        checks++; if (done_cnt != 1) begin errors++; $display("[TB] FAIL loop_done_pulses got %0d want 1", done_cnt); end
    endtask
`else
    task automatic test_stop_ignored();
        bit ok;
        bit reached;
        new_scenario();
        drive_start(40, 3);
        reached = 1'b0;
        for (int i = 0; i < 30 && !reached; i++) begin
            @(negedge clk);
            if (en_cnt >= 1) reached = 1'b1;
        end
        @(posedge clk); #1;
        stop = 1'b1;
        @(posedge clk); #1;
        stop = 1'b0;
        wait_done(60, ok);
        checks++; if (!reached || !ok) begin errors++; $display("[TB] FAIL stop_progress got reached=%b done=%b want 1 1", reached, ok); end
        checks++; if (q_data.size() != 3 || stream_mismatches(40, 3, 1) != 0) begin errors++; $display("[TB] FAIL stop_stream got n=%0d bad=%0d want 3 0", q_data.size(), stream_mismatches(40, 3, 1)); end
        checks++; if (done_cnt != 1) begin errors++; $display("[TB] FAIL stop_done_pulses got %0d want 1", done_cnt); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_wrap_edges();
        test_busy_start();
        test_reset_mid();
`ifdef RAM_READER_LOOP_EN
        test_loop();
`else
        test_stop_ignored();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog got timeout want completion");
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule
